// File: rtl/singlecycle_pkg.sv
// rtl/singlecycle_pkg.sv - shared types and widths for the iterative multiply/divide unit
package singlecycle_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    MDU_MUL   = 2'b00,
    MDU_MULHU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_MOD   = 2'b11
  } MDUOp_e;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_BUSY,
    MDU_DONE
  } MDUState_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// rtl/muldiv_iter_step.sv - one combinational shift-add or restoring-divide iteration
module muldiv_iter_step
  import singlecycle_pkg::*;
(
  input  logic            mul_en,
  input  logic [XLEN:0]   hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN:0]   hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0]   sum;
  logic [XLEN+1:0] trial;
  logic [XLEN:0]   diff;

  always_comb begin
    // Multiply: {hi, lo} is the product register, the carry lives in sum[XLEN]
    sum    = {1'b0, hi[XLEN-1:0]} + (lo[0] ? {1'b0, operand} : '0);
    // Divide: hi is the partial remainder, lo shifts the dividend out / quotient in
    trial  = {hi, lo[XLEN-1]};
    diff   = trial[XLEN:0] - {1'b0, operand};
    hi_nxt = '0;
    lo_nxt = '0;
    if (mul_en) begin
      hi_nxt = {1'b0, sum[XLEN:1]};
      lo_nxt = {sum[0], lo[XLEN-1:1]};
    end else if (trial >= {2'b00, operand}) begin
      hi_nxt = diff;
      lo_nxt = {lo[XLEN-2:0], 1'b1};
    end else begin
      hi_nxt = trial[XLEN:0];
      lo_nxt = {lo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative unsigned multiply/divide responder, one bit per cycle
module muldiv_iter
  import singlecycle_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_res,
  output logic            o_rsp_overflow
);

  MDUState_e        state_q, state_d;
  MDUOp_e           op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  opnd_q, lo_q, lo_nxt, res_q;
  logic [XLEN:0]    hi_q, hi_nxt;
  logic             ovf_q, accept, div0_req, last_step;

  assign div0_req  = i_op[1] && (i_operand_b == '0);
  assign last_step = (state_q == MDU_BUSY) && (cnt_q == '0);

  muldiv_iter_step u_step (
    .mul_en  (~op_q[1]),
    .hi      (hi_q),
    .lo      (lo_q),
    .operand (opnd_q),
    .hi_nxt  (hi_nxt),
    .lo_nxt  (lo_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= MDU_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      MDU_IDLE: if (i_req_valid) begin
        accept  = 1'b1;
        state_d = div0_req ? MDU_DONE : MDU_BUSY;
      end
      MDU_BUSY: if (cnt_q == '0) state_d = MDU_DONE;
      MDU_DONE: if (i_rsp_ready) state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    if (i_flush) begin
      state_d = MDU_IDLE;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q   <= MDU_MUL;
      cnt_q  <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      op_q  <= MDUOp_e'(i_op);
      cnt_q <= CNT_W'(XLEN - 1);
      hi_q  <= '0;
      // Multiplier seeds the product low half; dividend seeds the quotient shifter
      if (i_op[1]) begin
        opnd_q <= i_operand_b;
        lo_q   <= i_operand_a;
      end else begin
        opnd_q <= i_operand_a;
        lo_q   <= i_operand_b;
      end
      if (div0_req) begin
        res_q <= (i_op[0]) ? i_operand_a : '1;
        ovf_q <= 1'b1;
      end
    end else if (state_q == MDU_BUSY && !i_flush) begin
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
      if (last_step) begin
        case (op_q)
          MDU_MUL, MDU_DIV: res_q <= lo_nxt;
          default:          res_q <= hi_nxt[XLEN-1:0];
        endcase
        ovf_q <= ~op_q[1] && (hi_nxt[XLEN-1:0] != '0);
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign o_req_ready    = (state_q == MDU_IDLE);
  assign o_rsp_valid    = (state_q == MDU_DONE);
  assign o_rsp_res      = res_q;
  assign o_rsp_overflow = ovf_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - randomized and directed self-checking bench for muldiv_iter
module tb_muldiv_iter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_operand_a = '0;
  logic [31:0] i_operand_b = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_res;
  logic        o_rsp_overflow;

  int n_checks = 0;
  int n_fail = 0;

  muldiv_iter dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_flush        (i_flush),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_op           (i_op),
    .i_operand_a    (i_operand_a),
    .i_operand_b    (i_operand_b),
    .o_rsp_valid    (o_rsp_valid),
    .i_rsp_ready    (i_rsp_ready),
    .o_rsp_res      (o_rsp_res),
    .o_rsp_overflow (o_rsp_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, result} from plain 64-bit arithmetic and RV32M div-by-zero rules
  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00:   return {prod[63:32] != 0, prod[31:0]};
      2'b01:   return {prod[63:32] != 0, prod[63:32]};
      2'b10:   return (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
      default: return (b == 0) ? {1'b1, a} : {1'b0, a % b};
    endcase
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_rsp_valid && lat < 100) begin
      @(posedge i_clk);
      @(negedge i_clk);
      lat++;
    end
    if (!o_rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic handshake();
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
  endtask

  // Starts at a negedge in IDLE; ends at a negedge back in IDLE
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [32:0] exp;
    logic [31:0] held;
    int lat;
    exp = model(op, a, b);
    check("req_ready_idle", 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1;
    i_op = op;
    i_operand_a = a;
    i_operand_b = b;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_operand_a = $urandom;
    i_operand_b = $urandom;
    wait_valid(lat);
    check($sformatf("latency op%0d", op), lat, (op[1] && b == 0) ? 32'd0 : 32'd32);
    check($sformatf("res op%0d %h,%h", op, a, b), o_rsp_res, exp[31:0]);
    check($sformatf("ovf op%0d %h,%h", op, a, b), 32'(o_rsp_overflow), 32'(exp[32]));
    held = o_rsp_res;
    for (int i = 0; i < stall; i++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      check("stall_res", o_rsp_res, held);
      check("stall_req_ready", 32'(o_req_ready), 32'd0);
      check("stall_valid", 32'(o_rsp_valid), 32'd1);
    end
    handshake();
  endtask

  initial begin
    int lat;
    int seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    repeat (2) @(negedge i_clk);
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_res", o_rsp_res, 32'd0);
    check("rst_ovf", 32'(o_rsp_overflow), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_op(2'b00, 32'd7, 32'd6, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'd100, 32'd7, 0);
    run_op(2'b11, 32'd100, 32'd7, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(2'b10, 32'h1234, 32'd0, 0);
    run_op(2'b11, 32'h1234, 32'd0, 0);
    run_op(2'b11, 32'h8000_0001, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'h1234_5678, 32'd0, 0);
    run_op(2'b10, 32'd100, 32'd7, 5);

    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, int'($urandom_range(0, 2)));
    end

    // Request held high through BUSY must not be re-latched before the handshake
    i_req_valid = 1'b1;
    i_op = 2'b00;
    i_operand_a = 32'd3;
    i_operand_b = 32'd5;
    @(posedge i_clk);
    @(negedge i_clk);
    i_operand_a = 32'd2;
    i_operand_b = 32'd9;
    check("busy_req_ready", 32'(o_req_ready), 32'd0);
    wait_valid(lat);
    check("hold_first_res", o_rsp_res, 32'd15);
    check("hold_first_lat", lat, 32'd32);
    handshake();
    i_req_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    check("hold_second_accepted", 32'(o_req_ready), 32'd0);
    wait_valid(lat);
    check("hold_second_res", o_rsp_res, 32'd18);
    handshake();

    // Flush in the same cycle as a request: nothing accepted
    i_req_valid = 1'b1;
    i_flush = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_flush = 1'b0;
    check("flush_req_ready", 32'(o_req_ready), 32'd1);
    check("flush_req_valid", 32'(o_rsp_valid), 32'd0);

    // Flush in BUSY cycle 10
    i_req_valid = 1'b1;
    i_op = 2'b01;
    i_operand_a = 32'hDEAD_BEEF;
    i_operand_b = 32'h1234_5678;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    repeat (9) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
    i_flush = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b0;
    check("flush_busy_ready", 32'(o_req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_rsp_valid) seen++;
      @(negedge i_clk);
    end
    check("flush_no_rsp", seen, 32'd0);
    run_op(2'b00, 32'd3, 32'd5, 0);

    // Asynchronous reset mid-BUSY
    i_req_valid = 1'b1;
    i_op = 2'b10;
    i_operand_a = 32'd999;
    i_operand_b = 32'd3;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    repeat (10) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_req_ready", 32'(o_req_ready), 32'd1);
    check("arst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("arst_res", o_rsp_res, 32'd0);
    check("arst_ovf", 32'(o_rsp_overflow), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    run_op(2'b11, 32'd1000, 32'd9, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
